// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU and its sequencer:
// opcode encodings, sequencer state encoding and default datapath width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [2:0] OP_RESET = 3'b000;
    localparam logic [2:0] OP_NOR   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_XNOR  = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_RUN  = 3'd2,
        S_CAPT = 3'd3,
        S_RESP = 3'd4
    } seq_state_t;

    // True for the four opcodes the ALU implements.
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            OP_NOR, OP_ADD, OP_XNOR, OP_SUB: legal = 1'b1;
            default:                         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Initiator for the bit-serial ALU. Accepts one operation per request,
// holds operands on the ALU, drives the opcode for WIDTH bit-steps (after a
// one-cycle step-counter resync), then captures result and flags into a
// registered response port. Illegal opcodes are answered immediately with
// rsp_err set and never reach the ALU.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic [WIDTH-1:0] alu_srcA,
    output logic [WIDTH-1:0] alu_srcB,
    output logic [2:0]       alu_opCode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_sign,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_sign,
    output logic             rsp_err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_t       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [2:0]       op_q,         op_d;
    logic [WIDTH-1:0] a_q,          a_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic [2:0]       alu_op_q,     alu_op_d;
    logic             req_ready_q,  req_ready_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q,   rsp_zero_d;
    logic             rsp_carry_q,  rsp_carry_d;
    logic             rsp_sign_q,   rsp_sign_d;
    logic             rsp_err_q,    rsp_err_d;

    // Next-state, step counter, operand latch and response capture logic.
    // alu_op_d and req_ready_d are derived from the *next* state so that the
    // registered outputs line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        alu_op_d     = OP_RESET;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_sign_d   = rsp_sign_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    a_d   = req_a;
                    b_d   = req_b;
                    op_d  = req_op;
                    cnt_d = {CNT_W{1'b0}};
                    if (is_legal_op(req_op)) begin
                        state_d = S_SYNC;
                    end else begin
                        state_d      = S_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_err_d    = 1'b1;
                        rsp_result_d = {WIDTH{1'b0}};
                        rsp_zero_d   = 1'b0;
                        rsp_carry_d  = 1'b0;
                        rsp_sign_d   = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SYNC: begin
                state_d  = S_RUN;
                cnt_d    = {CNT_W{1'b0}};
                alu_op_d = op_q;
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_CAPT;
                    cnt_d    = {CNT_W{1'b0}};
                    alu_op_d = OP_RESET;
                end else begin
                    state_d  = S_RUN;
                    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    alu_op_d = op_q;
                end
            end
            S_CAPT: begin
                state_d      = S_RESP;
                rsp_valid_d  = 1'b1;
                rsp_err_d    = 1'b0;
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_carry_d  = alu_carry;
                rsp_sign_d   = alu_sign;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = {CNT_W{1'b0}};
                rsp_valid_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    // State and output registers; synchronous reset abandons any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            op_q         <= OP_RESET;
            a_q          <= {WIDTH{1'b0}};
            b_q          <= {WIDTH{1'b0}};
            alu_op_q     <= OP_RESET;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= {WIDTH{1'b0}};
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_sign_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            alu_op_q     <= alu_op_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_sign_q   <= rsp_sign_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign alu_srcA   = a_q;
    assign alu_srcB   = b_q;
    assign alu_opCode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_sign   = rsp_sign_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Initiator for the bit-serial 4-bit ALU. It accepts one operation per request over a valid/ready handshake and holds the operands stable on the ALU inputs. It drives the ALU opcode for exactly one bit-step per cycle, then captures the final result and flags into a registered response port with its own valid/ready handshake. It sits between the instruction/control path and the ALU, so that no upstream block needs to know the ALU's internal bit-step count.

## Interface
- WIDTH, 4, operand width = number of serial bit-steps; must equal ALU width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_op  in  3  001 NOR, 010 ADD, 011 XNOR, 100 SUB; others illegal
- alu_srcA  out  WIDTH  registered operand A to ALU
- alu_srcB  out  WIDTH  registered operand B to ALU
- alu_opCode  out  3  registered opcode to ALU; 000 = ALU bit-step reset / idle
- alu_result  in  WIDTH  ALU result
- alu_zero, alu_carry, alu_sign  in  1 each  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_result  out  WIDTH  captured result
- rsp_zero, rsp_carry, rsp_sign  out  1 each  captured flags (carry = borrow for SUB)
- rsp_err  out  1  illegal opcode; result and flags forced 0

## Operation
- States are IDLE, SYNC, RUN, CAPT, RESP.
- IDLE: req_ready=1 and alu_opCode=000. When req_valid is high, latch req_a/req_b/req_op at the edge.
  - Legal op: go to SYNC.
  - Illegal op: go to RESP with rsp_err=1 and rsp_result/flags=0. No ALU activity; alu_opCode stays 000.
- SYNC: one cycle with alu_opCode=000, which forces the ALU bit-step counter to 0. Next state is RUN with cnt=0.
- RUN: alu_opCode=latched op for WIDTH cycles.
  - cnt increments 0..WIDTH-1.
  - At cnt==WIDTH-1, go to CAPT.
- CAPT: alu_opCode=000, which freezes the ALU outputs. On the exiting edge, register alu_result/alu_zero/alu_carry/alu_sign into the rsp_* outputs, set rsp_err=0, and go to RESP.
- RESP: rsp_valid=1, and rsp_* stay stable until rsp_ready. On the handshake edge, clear rsp_valid and go to IDLE.
- alu_srcA/alu_srcB stay constant from SYNC through CAPT. Intermediate ALU flags during RUN are ignored; only the post-last-step values are captured.
- There is no request/response bypass. req_ready is low whenever the state is not IDLE.

## Timing
- Edges are numbered relative to accept edge E0 (req_valid & req_ready):
  - after E0: SYNC
  - after E1..E4: RUN cnt 0..3 (WIDTH=4); the ALU computes bit k at edge E(k+2)
  - after E5: CAPT, ALU outputs final
  - after E6: RESP, rsp_valid=1
- Legal-op latency is WIDTH+2 edges from accept to rsp_valid.
- Illegal op: rsp_valid=1 after E0.
- Back-to-back throughput with rsp_ready tied high: handshake at E7, IDLE after E7, next accept at E8. One op per WIDTH+4 cycles.
- Reset value of every output is 0: req_ready=0 during reset, and 1 in the first cycle after reset deasserts. Reset also clears state to IDLE, cnt=0 and all latches.
- Reset mid-operation, in any state: the operation is abandoned with no response. alu_opCode returns to 000 the cycle after, which also re-syncs the ALU.
- req_valid asserted outside IDLE is ignored, with no latching.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_RESET=000, OP_NOR=001, OP_ADD=010, OP_XNOR=011, OP_SUB=100
  - the state enum typedef
  - the default width constant
- The ALU uses the same opcode constants from that package.
- The block is a single module: one FSM plus a $clog2(WIDTH)-bit step counter. No sub-module.

## Test plan
- ADD a=0111, b=0001 -> rsp_result=1000, zero=0, carry=0, sign=1, err=0; rsp_valid exactly 6 edges after accept.
- SUB a=0011, b=0101 -> rsp_result=1110, carry(borrow)=1, sign=1, zero=0.
- NOR a=1010, b=0101, with rsp_ready held low 5 cycles -> rsp_result=0000, zero=1, carry=0, sign=0. Response stays stable and req_ready stays 0 until the handshake.
- Illegal op 110 -> rsp_valid after 1 edge with rsp_err=1 and result/flags 0; alu_opCode never leaves 000.
- Reset pulsed while in RUN cnt=2 -> next cycle all outputs 0 and no rsp_valid. A following ADD 1111+0001 -> 0000, carry=1, zero=1.
- Two XNOR requests, rsp_ready tied 1, 1100 xnor 1010 then 0000 xnor 0000 -> results 1001 then 1111, sign=1. Second accept exactly 8 edges after first.
